// File: rtl/regbank_pkg.sv
// Shared types and constants for the configuration register bank arbiter.
// Holds the FSM state encoding, requester ids and the default bank geometry.
package regbank_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COMMIT = 2'd1,
    LOCKED = 2'd2
  } arb_state_t;

  localparam logic REQ_I2C = 1'b0;
  localparam logic REQ_PAR = 1'b1;

  localparam int DATA_W               = 8;
  localparam int REGCOUNT_DEFAULT     = 20;
  localparam int ADDR_W_DEFAULT       = 5;
  localparam int LOCK_TIMEOUT_DEFAULT = 255;
  localparam int WPROT_BASE_DEFAULT   = 16;

  function automatic logic [1:0] req_onehot(input logic id);
    return (id == REQ_PAR) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: a lone requester always wins, and on a tie the
// requester that did not win last time is chosen.
module rr_arbiter2
  import regbank_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_id
);

  always_comb begin
    grant_valid = |valid;
    grant_id    = REQ_I2C;
    if (valid == 2'b11) begin
      grant_id = ~last_grant;
    end else if (valid[REQ_PAR]) begin
      grant_id = REQ_PAR;
    end
  end

endmodule

// File: rtl/regbank_arbiter.sv
// Shared configuration register bank with round-robin write arbitration,
// an I2C burst lock with timeout and sticky error flags.
// Define REGBANK_WPROT_EN to drop requester 1 writes at or above WPROT_BASE.
module regbank_arbiter
  import regbank_pkg::*;
#(
  parameter int REGCOUNT     = REGCOUNT_DEFAULT,
  parameter int ADDR_W       = ADDR_W_DEFAULT,
  parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEFAULT,
  parameter int WPROT_BASE   = WPROT_BASE_DEFAULT
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [1:0]                 req_valid,
  input  logic                       req_lock,
  input  logic [ADDR_W-1:0]          req_addr0,
  input  logic [DATA_W-1:0]          req_data0,
  input  logic [ADDR_W-1:0]          req_addr1,
  input  logic [DATA_W-1:0]          req_data1,
  input  logic                       err_clr,
  output logic [1:0]                 req_ready,
  output logic                       grant_id,
  output logic                       busy,
  output logic                       err_oob,
  output logic                       err_timeout,
  output logic [DATA_W*REGCOUNT-1:0] registers_packed
);

  localparam int CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [ADDR_W:0]   REGCOUNT_LIM = (ADDR_W + 1)'(REGCOUNT);
  localparam logic [ADDR_W:0]   WPROT_LIM    = (ADDR_W + 1)'(WPROT_BASE);

`ifdef REGBANK_WPROT_EN
  localparam logic WPROT_ON = 1'b1;
`else
  localparam logic WPROT_ON = 1'b0;
`endif

  arb_state_t              state_q, state_d;
  logic                    last_grant_q, last_grant_d;
  logic                    grant_id_q, grant_id_d;
  logic                    win_id_q, win_id_d;
  logic [ADDR_W-1:0]       win_addr_q, win_addr_d;
  logic [DATA_W-1:0]       win_data_q, win_data_d;
  logic                    win_lock_q, win_lock_d;
  logic [CNT_W-1:0]        lock_cnt_q, lock_cnt_d;
  logic                    err_oob_q, err_oob_d;
  logic                    err_timeout_q, err_timeout_d;
  logic [DATA_W-1:0]       bank_q [REGCOUNT];
  logic [DATA_W-1:0]       bank_d [REGCOUNT];

  logic                    arb_valid;
  logic                    arb_id;
  logic                    addr_oob;
  logic                    wprot_hit;
  logic                    write_drop;
  logic                    oob_evt;
  logic                    tmo_evt;

  rr_arbiter2 u_rr (
    .valid       (req_valid),
    .last_grant  (last_grant_q),
    .grant_valid (arb_valid),
    .grant_id    (arb_id)
  );

  // Write-protection only ever targets the parallel sampler.
  assign addr_oob   = {1'b0, win_addr_q} >= REGCOUNT_LIM;
  assign wprot_hit  = WPROT_ON && (win_id_q == REQ_PAR) && ({1'b0, win_addr_q} >= WPROT_LIM);
  assign write_drop = addr_oob || wprot_hit;

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    grant_id_d    = grant_id_q;
    win_id_d      = win_id_q;
    win_addr_d    = win_addr_q;
    win_data_d    = win_data_q;
    win_lock_d    = win_lock_q;
    lock_cnt_d    = lock_cnt_q;
    bank_d        = bank_q;
    oob_evt       = 1'b0;
    tmo_evt       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          win_id_d   = arb_id;
          win_addr_d = (arb_id == REQ_PAR) ? req_addr1 : req_addr0;
          win_data_d = (arb_id == REQ_PAR) ? req_data1 : req_data0;
          win_lock_d = (arb_id == REQ_I2C) && req_lock;
          state_d    = COMMIT;
        end
      end
      COMMIT: begin
        if (write_drop) begin
          oob_evt = 1'b1;
        end else begin
          for (int i = 0; i < REGCOUNT; i++) begin
            if (win_addr_q == ADDR_W'(i)) begin
              bank_d[i] = win_data_q;
            end
          end
        end
        grant_id_d   = win_id_q;
        last_grant_d = win_id_q;
        lock_cnt_d   = '0;
        state_d      = ((win_id_q == REQ_I2C) && win_lock_q) ? LOCKED : IDLE;
      end
      LOCKED: begin
        // The I2C master owns the bank; the sampler stalls until release.
        if (req_valid[REQ_I2C]) begin
          win_id_d   = REQ_I2C;
          win_addr_d = req_addr0;
          win_data_d = req_data0;
          win_lock_d = req_lock;
          lock_cnt_d = '0;
          state_d    = COMMIT;
        end else if (!req_lock) begin
          lock_cnt_d = '0;
          state_d    = IDLE;
        end else if (lock_cnt_q == CNT_LAST) begin
          tmo_evt    = 1'b1;
          lock_cnt_d = '0;
          state_d    = IDLE;
        end else begin
          lock_cnt_d = lock_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A fresh error event outranks a simultaneous clear.
    err_oob_d     = (err_oob_q && !err_clr) || oob_evt;
    err_timeout_d = (err_timeout_q && !err_clr) || tmo_evt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      last_grant_q  <= REQ_PAR;
      grant_id_q    <= REQ_I2C;
      win_id_q      <= REQ_I2C;
      win_addr_q    <= '0;
      win_data_q    <= '0;
      win_lock_q    <= 1'b0;
      lock_cnt_q    <= '0;
      err_oob_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      bank_q        <= '{default: '0};
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      grant_id_q    <= grant_id_d;
      win_id_q      <= win_id_d;
      win_addr_q    <= win_addr_d;
      win_data_q    <= win_data_d;
      win_lock_q    <= win_lock_d;
      lock_cnt_q    <= lock_cnt_d;
      err_oob_q     <= err_oob_d;
      err_timeout_q <= err_timeout_d;
      bank_q        <= bank_d;
    end
  end

  assign req_ready   = (state_q == COMMIT) ? req_onehot(win_id_q) : 2'b00;
  assign busy        = (state_q != IDLE);
  assign grant_id    = grant_id_q;
  assign err_oob     = err_oob_q;
  assign err_timeout = err_timeout_q;

  for (genvar g = 0; g < REGCOUNT; g++) begin : g_pack
    assign registers_packed[DATA_W*g +: DATA_W] = bank_q[g];
  end

endmodule

// File: tb/tb_regbank_arbiter.sv
// Self-checking bench for regbank_arbiter: directed scenarios plus randomized
// traffic, checked every cycle against a behavioural model of the bank.
module tb_regbank_arbiter;

  localparam int REGCOUNT     = 20;
  localparam int ADDR_W       = 5;
  localparam int LOCK_TIMEOUT = 4;
  localparam int WPROT_BASE   = 16;
  localparam int CW           = 8 * REGCOUNT;

`ifdef REGBANK_WPROT_EN
  localparam bit WPROT = 1'b1;
`else
  localparam bit WPROT = 1'b0;
`endif

  typedef logic [CW-1:0] cval_t;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
    logic              lock;
  } txn_t;

  logic              clock = 1'b0;
  logic              reset_n = 1'b1;
  logic [1:0]        req_valid = '0;
  logic              req_lock = 1'b0;
  logic [ADDR_W-1:0] req_addr0 = '0;
  logic [7:0]        req_data0 = '0;
  logic [ADDR_W-1:0] req_addr1 = '0;
  logic [7:0]        req_data1 = '0;
  logic              err_clr = 1'b0;
  logic [1:0]        req_ready;
  logic              grant_id;
  logic              busy;
  logic              err_oob;
  logic              err_timeout;
  logic [CW-1:0]     registers_packed;

  regbank_arbiter #(
    .REGCOUNT     (REGCOUNT),
    .ADDR_W       (ADDR_W),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .WPROT_BASE   (WPROT_BASE)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_lock         (req_lock),
    .req_addr0        (req_addr0),
    .req_data0        (req_data0),
    .req_addr1        (req_addr1),
    .req_data1        (req_data1),
    .err_clr          (err_clr),
    .req_ready        (req_ready),
    .grant_id         (grant_id),
    .busy             (busy),
    .err_oob          (err_oob),
    .err_timeout      (err_timeout),
    .registers_packed (registers_packed)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Requester agents and bookkeeping
  txn_t q0[$];
  txn_t q1[$];
  int   serve_log[$];
  bit   lock_hold = 1'b0;
  bit   clr_on_commit = 1'b0;
  bit   rand_mode = 1'b0;
  int   busy_cycles = 0;

  // Reference model
  logic [7:0] m_bank [REGCOUNT];
  bit         m_commit, m_locked, m_wid, m_wlock, m_last, m_grant, m_oob, m_tmo;
  int         m_waddr, m_cnt;
  logic [7:0] m_wdata;

  task automatic checkOutput(input string tag, input cval_t actual, input cval_t expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic txn_t mkTxn(input int a, input int d, input bit l);
    txn_t t;
    t.addr = ADDR_W'(a);
    t.data = 8'(d);
    t.lock = l;
    return t;
  endfunction

  function automatic cval_t modelPacked();
    cval_t v = '0;
    for (int i = 0; i < REGCOUNT; i++) v[8*i +: 8] = m_bank[i];
    return v;
  endfunction

  function automatic cval_t packOrder(input int q[$]);
    cval_t v = '0;
    foreach (q[i]) v = (v << 2) | cval_t'(q[i] + 1);
    return v;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < REGCOUNT; i++) m_bank[i] = 8'h00;
    m_commit = 0; m_locked = 0; m_wid = 0; m_wlock = 0;
    m_last = 1; m_grant = 0; m_oob = 0; m_tmo = 0;
    m_waddr = 0; m_cnt = 0; m_wdata = 8'h00;
  endtask

  task automatic modelTake(input bit w);
    m_commit = 1;
    m_locked = 0;
    m_wid    = w;
    m_waddr  = w ? int'(req_addr1) : int'(req_addr0);
    m_wdata  = w ? req_data1 : req_data0;
    m_wlock  = !w && req_lock;
    m_cnt    = 0;
  endtask

  // Advance the model across the clock edge just taken, using the inputs
  // that were held during the preceding cycle.
  task automatic modelStep();
    bit drop, tmo;
    drop = 0;
    tmo  = 0;
    if (m_commit) begin
      drop = (m_waddr >= REGCOUNT) || (WPROT && m_wid && m_waddr >= WPROT_BASE);
      if (!drop) m_bank[m_waddr] = m_wdata;
      m_grant  = m_wid;
      m_last   = m_wid;
      m_commit = 0;
      m_locked = !m_wid && m_wlock;
      m_cnt    = 0;
    end else if (m_locked) begin
      if (req_valid[0]) modelTake(0);
      else if (!req_lock) m_locked = 0;
      else if (m_cnt == LOCK_TIMEOUT - 1) begin
        tmo = 1; m_locked = 0; m_cnt = 0;
      end else m_cnt++;
    end else if (req_valid != 2'b00) begin
      if (req_valid == 2'b11) modelTake(!m_last);
      else modelTake(req_valid[1]);
    end
    m_oob = (m_oob && !err_clr) || drop;
    m_tmo = (m_tmo && !err_clr) || tmo;
  endtask

  task automatic compareOutputs();
    checkOutput("req_ready", cval_t'(req_ready), m_commit ? (m_wid ? cval_t'(2) : cval_t'(1)) : cval_t'(0));
    checkOutput("busy", cval_t'(busy), cval_t'(m_commit || m_locked));
    checkOutput("grant_id", cval_t'(grant_id), cval_t'(m_grant));
    checkOutput("err_oob", cval_t'(err_oob), cval_t'(m_oob));
    checkOutput("err_timeout", cval_t'(err_timeout), cval_t'(m_tmo));
    checkOutput("bank", registers_packed, modelPacked());
  endtask

  task automatic presentRequests();
    req_valid[0] = (q0.size() > 0);
    req_valid[1] = (q1.size() > 0);
    if (q0.size() > 0) begin
      req_addr0 = q0[0].addr;
      req_data0 = q0[0].data;
      req_lock  = q0[0].lock;
    end else begin
      req_lock  = lock_hold;
    end
    if (q1.size() > 0) begin
      req_addr1 = q1[0].addr;
      req_data1 = q1[0].data;
    end
  endtask

  task automatic applyStimulus();
    if (req_ready[0] && req_valid[0] && q0.size() > 0) begin
      void'(q0.pop_front());
      serve_log.push_back(0);
    end
    if (req_ready[1] && req_valid[1] && q1.size() > 0) begin
      void'(q1.pop_front());
      serve_log.push_back(1);
    end
    if (rand_mode) begin
      if (q0.size() < 2 && $urandom_range(0, 2) == 0)
        q0.push_back(mkTxn($urandom_range(0, REGCOUNT + 3), $urandom_range(0, 255), $urandom_range(0, 3) == 0));
      if (q1.size() < 2 && $urandom_range(0, 2) == 0)
        q1.push_back(mkTxn($urandom_range(0, REGCOUNT + 3), $urandom_range(0, 255), 1'b0));
      if ($urandom_range(0, 31) == 0) lock_hold = !lock_hold;
    end
    presentRequests();
    err_clr = rand_mode ? ($urandom_range(0, 15) == 0) : (clr_on_commit && m_commit);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    modelStep();
    compareOutputs();
    if (busy) busy_cycles++;
    applyStimulus();
  endtask

  task automatic drainAll(input int max_cycles);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m_commit || m_locked) && n < max_cycles) begin
      tick();
      n++;
    end
    tick();
    checkOutput("drain_bound", cval_t'(n < max_cycles), cval_t'(1));
  endtask

  task automatic resetDut();
    reset_n   = 1'b0;
    req_valid = '0;
    req_lock  = 1'b0;
    err_clr   = 1'b0;
    lock_hold = 1'b0;
    q0.delete();
    q1.delete();
    serve_log.delete();
    #1;
    checkOutput("rst_ready", cval_t'(req_ready), cval_t'(0));
    checkOutput("rst_busy", cval_t'(busy), cval_t'(0));
    checkOutput("rst_grant", cval_t'(grant_id), cval_t'(0));
    checkOutput("rst_errs", cval_t'({err_oob, err_timeout}), cval_t'(0));
    checkOutput("rst_bank", registers_packed, cval_t'(0));
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    modelReset();
    busy_cycles = 0;
  endtask

  initial begin
    int exp_order[$];
    int n;
    #2;

    // Single write latency and data placement
    resetDut();
    q0.push_back(mkTxn(3, 8'hA5, 0));
    presentRequests();
    drainAll(20);
    checkOutput("s1_reg3", cval_t'(registers_packed[31:24]), cval_t'(8'hA5));
    checkOutput("s1_grant", cval_t'(grant_id), cval_t'(0));
    checkOutput("s1_busy_cycles", cval_t'(busy_cycles), cval_t'(1));

    // Round-robin alternation under continuous contention
    resetDut();
    q0.push_back(mkTxn(1, 8'h11, 0));
    q0.push_back(mkTxn(1, 8'h33, 0));
    q1.push_back(mkTxn(2, 8'h22, 0));
    q1.push_back(mkTxn(2, 8'h44, 0));
    presentRequests();
    drainAll(30);
    exp_order = '{0, 1, 0, 1};
    checkOutput("s2_order", packOrder(serve_log), packOrder(exp_order));
    checkOutput("s2_reg1", cval_t'(registers_packed[15:8]), cval_t'(8'h33));
    checkOutput("s2_reg2", cval_t'(registers_packed[23:16]), cval_t'(8'h44));

    // Lock burst keeps requester 1 out until the lock drops
    resetDut();
    q0.push_back(mkTxn(4, 8'hA1, 1));
    q0.push_back(mkTxn(5, 8'hA2, 1));
    q0.push_back(mkTxn(6, 8'hA3, 0));
    q1.push_back(mkTxn(7, 8'hB1, 0));
    presentRequests();
    drainAll(30);
    exp_order = '{0, 0, 0, 1};
    checkOutput("s3_order", packOrder(serve_log), packOrder(exp_order));
    checkOutput("s3_regs", cval_t'(registers_packed[63:32]), cval_t'(32'hB1A3A2A1));

    // Lock held with no further I2C traffic times out
    resetDut();
    lock_hold = 1'b1;
    q0.push_back(mkTxn(8, 8'hC1, 1));
    q1.push_back(mkTxn(9, 8'hD1, 0));
    presentRequests();
    drainAll(30);
    lock_hold = 1'b0;
    exp_order = '{0, 1};
    checkOutput("s4_order", packOrder(serve_log), packOrder(exp_order));
    checkOutput("s4_timeout", cval_t'(err_timeout), cval_t'(1));
    checkOutput("s4_reg9", cval_t'(registers_packed[79:72]), cval_t'(8'hD1));

    // Out-of-range address, clear, then clear colliding with a new error
    resetDut();
    q0.push_back(mkTxn(20, 8'hEE, 0));
    presentRequests();
    drainAll(20);
    checkOutput("s5_oob_set", cval_t'(err_oob), cval_t'(1));
    checkOutput("s5_bank_clean", registers_packed, cval_t'(0));
    err_clr = 1'b1;
    tick();
    checkOutput("s5_oob_clr", cval_t'(err_oob), cval_t'(0));
    clr_on_commit = 1'b1;
    q1.push_back(mkTxn(21, 8'h99, 0));
    presentRequests();
    drainAll(20);
    clr_on_commit = 1'b0;
    checkOutput("s5_set_wins", cval_t'(err_oob), cval_t'(1));

    // Write protection on the upper registers for requester 1
    resetDut();
    q1.push_back(mkTxn(16, 8'h5A, 0));
    presentRequests();
    drainAll(20);
    checkOutput("s6_req1_reg16", cval_t'(registers_packed[135:128]), WPROT ? cval_t'(8'h00) : cval_t'(8'h5A));
    checkOutput("s6_req1_oob", cval_t'(err_oob), cval_t'(WPROT));
    q0.push_back(mkTxn(16, 8'hC3, 0));
    presentRequests();
    drainAll(20);
    checkOutput("s6_req0_reg16", cval_t'(registers_packed[135:128]), cval_t'(8'hC3));

    // Reset landing in the commit cycle aborts the write
    resetDut();
    q0.push_back(mkTxn(1, 8'h11, 0));
    presentRequests();
    drainAll(20);
    checkOutput("s7_pre_reg1", cval_t'(registers_packed[15:8]), cval_t'(8'h11));
    q0.push_back(mkTxn(2, 8'h77, 0));
    presentRequests();
    n = 0;
    while (!m_commit && n < 10) begin
      tick();
      n++;
    end
    checkOutput("s7_commit_bound", cval_t'(n < 10), cval_t'(1));
    #2;
    resetDut();
    tick();
    tick();
    checkOutput("s7_bank_after", registers_packed, cval_t'(0));

    // Randomized traffic against the model
    resetDut();
    rand_mode = 1'b1;
    repeat (1500) tick();
    rand_mode = 1'b0;
    lock_hold = 1'b0;
    presentRequests();
    drainAll(200);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
